// File: rtl/inst_encoder.sv
// RV32I instruction assembler: packs decoded fields and a 32-bit immediate into an instruction word.
// Two-stage valid/ready pipeline; immediate range violations or a reserved format produce a NOP with out_err set.
module inst_encoder #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_fmt,
   input  logic [6:0]         in_opcode,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [31:0]        in_imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic               out_err,
   output logic [COUNT_W-1:0] enc_count,
   output logic [COUNT_W-1:0] err_count
);

   localparam logic [2:0]  FMT_R   = 3'd0;
   localparam logic [2:0]  FMT_I   = 3'd1;
   localparam logic [2:0]  FMT_ISH = 3'd2;
   localparam logic [2:0]  FMT_S   = 3'd3;
   localparam logic [2:0]  FMT_B   = 3'd4;
   localparam logic [2:0]  FMT_U   = 3'd5;
   localparam logic [2:0]  FMT_J   = 3'd6;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        err;
   } req_t;

   logic               s1_valid_q, s1_valid_d;
   req_t               s1_req_q, s1_req_d;
   logic               s2_valid_q, s2_valid_d;
   logic [31:0]        out_inst_q, out_inst_d;
   logic               out_err_q, out_err_d;
   logic [COUNT_W-1:0] enc_count_q, enc_count_d;
   logic [COUNT_W-1:0] err_count_q, err_count_d;

   logic        s2_adv;
   logic        range_err;
   req_t        in_req;
   logic [31:0] enc_inst;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign in_ready = !flush && (!s1_valid_q || s2_adv);

   // Upper immediate bits must be a pure sign extension of the slot's top bit.
   always_comb begin
      range_err = 1'b0;
      case (in_fmt)
         FMT_R:        range_err = 1'b0;
         FMT_I, FMT_S: range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         FMT_ISH:      range_err = |in_imm[31:5];
         FMT_B:        range_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
         FMT_U:        range_err = |in_imm[11:0];
         FMT_J:        range_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
         default:      range_err = 1'b1;
      endcase
   end

   always_comb begin
      in_req        = '0;
      in_req.fmt    = in_fmt;
      in_req.opcode = in_opcode;
      in_req.funct3 = in_funct3;
      in_req.funct7 = in_funct7;
      in_req.rd     = in_rd;
      in_req.rs1    = in_rs1;
      in_req.rs2    = in_rs2;
      in_req.imm    = in_imm;
      in_req.err    = range_err;
   end

   always_comb begin
      enc_inst = NOP_INST;
      case (s1_req_q.fmt)
         FMT_R:   enc_inst = {s1_req_q.funct7, s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.rd, s1_req_q.opcode};
         FMT_I:   enc_inst = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.rd, s1_req_q.opcode};
         FMT_ISH: enc_inst = {s1_req_q.funct7, s1_req_q.imm[4:0], s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.rd, s1_req_q.opcode};
         FMT_S:   enc_inst = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.imm[4:0], s1_req_q.opcode};
         FMT_B:   enc_inst = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2, s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.imm[4:1], s1_req_q.imm[11], s1_req_q.opcode};
         FMT_U:   enc_inst = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
         FMT_J:   enc_inst = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                              s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
         default: enc_inst = NOP_INST;
      endcase
      if (s1_req_q.err) enc_inst = NOP_INST;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_req_d    = s1_req_q;
      s2_valid_d  = s2_valid_q;
      out_inst_d  = out_inst_q;
      out_err_d   = out_err_q;
      enc_count_d = enc_count_q;
      err_count_d = err_count_q;

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               out_inst_d = enc_inst;
               out_err_d  = s1_req_q.err;
            end
         end
         if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_req_d = in_req;
         end
      end

      // A word popped in the same cycle as a flush still counts as delivered.
      if (s2_valid_q && out_ready) begin
         enc_count_d = enc_count_q + COUNT_W'(1);
         if (out_err_q && !(&err_count_q)) err_count_d = err_count_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_req_q    <= '0;
         s2_valid_q  <= 1'b0;
         out_inst_q  <= '0;
         out_err_q   <= 1'b0;
         enc_count_q <= '0;
         err_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_req_q    <= s1_req_d;
         s2_valid_q  <= s2_valid_d;
         out_inst_q  <= out_inst_d;
         out_err_q   <= out_err_d;
         enc_count_q <= enc_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_inst  = out_inst_q;
   assign out_err   = out_err_q;
   assign enc_count = enc_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, range errors, backpressure, flush, reset.
// A second instance with 4-bit counters exercises wrap and saturation.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_err;
   logic [31:0] out_inst;
   logic [15:0] enc_count, err_count;
   logic        in_ready4, out_valid4, out_err4;
   logic [31:0] out_inst4;
   logic [3:0]  enc_count4, err_count4;

   int n_vec  = 0;
   int n_miss = 0;
   logic [15:0] exp_enc = '0;
   logic [15:0] exp_err = '0;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   inst_encoder #(.COUNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
      .enc_count(enc_count), .err_count(err_count)
   );

   inst_encoder #(.COUNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4), .out_err(out_err4),
      .enc_count(enc_count4), .err_count(err_count4)
   );

   always #5 clk = ~clk;

   task automatic drive_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
      in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_enc = '0;
      exp_err = '0;
   endtask

   // Sends one request into an empty pipeline and waits (bounded) for its word.
   task automatic run_single(input vec_t v, output logic [31:0] inst, output logic err,
                             output bit seen, output int lat);
      @(negedge clk);
      out_ready = 1'b1;
      drive_req(v.fmt, v.op, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0; lat = 1; inst = 'x; err = 1'bx;
      repeat (6) begin
         if (!seen && out_valid === 1'b1) begin
            seen = 1'b1; inst = out_inst; err = out_err;
         end else if (!seen) begin
            lat++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (out_inst !== 32'h0) begin n_miss++; $display("FAIL reset_out_inst got %h want 00000000", out_inst); end
      n_vec++; if (out_err !== 1'b0) begin n_miss++; $display("FAIL reset_out_err got %b want 0", out_err); end
      n_vec++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin
         n_miss++; $display("FAIL reset_counters got %h/%h want 0000/0000", enc_count, err_count);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_encode();
      vec_t q[$];
      logic [31:0] inst; logic err; bit seen; int lat;
      q.push_back('{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0});
      q.push_back('{3'd3, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h0000_0008, 32'h0051_2423, 1'b0});
      q.push_back('{3'd4, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0});
      q.push_back('{3'd6, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0});
      q.push_back('{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0});
      q.push_back('{3'd2, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'h0000_0003, 32'h4030_D093, 1'b0});
      q.push_back('{3'd5, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0});
      q.push_back('{3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0013, 1'b0});
      q.push_back('{3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0});
      q.push_back('{3'd4, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0});
      q.push_back('{3'd6, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0});
      foreach (q[i]) begin
         run_single(q[i], inst, err, seen, lat);
         exp_enc++;
         n_vec++; if (!seen) begin n_miss++; $display("FAIL enc[%0d]_timeout got no out_valid want out_valid", i); end
         n_vec++; if (lat != 2) begin n_miss++; $display("FAIL enc[%0d]_latency got %0d want 2", i, lat); end
         n_vec++; if (inst !== q[i].inst || err !== q[i].err) begin
            n_miss++; $display("FAIL enc[%0d]_word got %h err %b want %h err %b", i, inst, err, q[i].inst, q[i].err);
         end
      end
      n_vec++; if (enc_count !== exp_enc || err_count !== exp_err) begin
         n_miss++; $display("FAIL enc_counters got %0d/%0d want %0d/%0d", enc_count, err_count, exp_enc, exp_err);
      end
   endtask

   task automatic test_errors();
      vec_t q[$];
      logic [31:0] inst; logic err; bit seen; int lat;
      q.push_back('{3'd4, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 32'h0000_0013, 1'b1});
      q.push_back('{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'h0000_0800, 32'h0000_0013, 1'b1});
      q.push_back('{3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'h0000_0000, 32'h0000_0013, 1'b1});
      q.push_back('{3'd2, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'h0000_0020, 32'h0000_0013, 1'b1});
      q.push_back('{3'd5, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1});
      q.push_back('{3'd6, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0013, 1'b1});
      q.push_back('{3'd3, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1});
      foreach (q[i]) begin
         run_single(q[i], inst, err, seen, lat);
         exp_enc++;
         exp_err++;
         n_vec++; if (!seen || inst !== q[i].inst || err !== q[i].err) begin
            n_miss++; $display("FAIL err[%0d]_word got %h err %b seen %0d want %h err %b", i, inst, err, seen, q[i].inst, q[i].err);
         end
         n_vec++; if (err_count !== exp_err) begin
            n_miss++; $display("FAIL err[%0d]_err_count got %0d want %0d", i, err_count, exp_err);
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2);
      @(posedge clk);
      @(negedge clk);
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
         n_vec++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_0093) begin
            n_miss++; $display("FAIL bp_hold[%0d] got v%b %h want v1 00100093", k, out_valid, out_inst);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_inst !== 32'h0020_0113) begin
         n_miss++; $display("FAIL bp_second got v%b %h want v1 00200113", out_valid, out_inst);
      end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_inst !== 32'h0030_0193) begin
         n_miss++; $display("FAIL bp_third got v%b %h want v1 00300193", out_valid, out_inst);
      end
      @(negedge clk);
      exp_enc += 3;
      n_vec++; if (out_valid !== 1'b0 || enc_count !== exp_enc) begin
         n_miss++; $display("FAIL bp_drain got v%b cnt %0d want v0 cnt %0d", out_valid, enc_count, exp_enc);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      out_ready = 1'b0;
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4);
      @(posedge clk);
      @(negedge clk);
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd5);
      @(posedge clk);
      @(negedge clk);
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0, 32'd6);
      flush = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_drained[%0d] got %b want 0", k, out_valid); end
      end
      n_vec++; if (enc_count !== exp_enc) begin
         n_miss++; $display("FAIL flush_no_count got %0d want %0d", enc_count, exp_enc);
      end
      // Flush in the same cycle the held word is taken: it still counts.
      out_ready = 1'b0;
      drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'd7);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_inst !== 32'h0070_0393) begin
         n_miss++; $display("FAIL flush_pop_word got v%b %h want v1 00700393", out_valid, out_inst);
      end
      flush = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_enc++;
      n_vec++; if (out_valid !== 1'b0 || enc_count !== exp_enc) begin
         n_miss++; $display("FAIL flush_pop_count got v%b cnt %0d want v0 cnt %0d", out_valid, enc_count, exp_enc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want;
      pulse_reset();
      for (int t = 0; t < 22; t++) begin
         if (t >= 2) begin
            want = ((t - 2) << 20) | ((t - 2) << 7) | 32'h13;
            n_vec++; if (out_valid !== 1'b1 || out_inst !== want) begin
               n_miss++; $display("FAIL b2b_word[%0d] got v%b %h want v1 %h", t - 2, out_valid, out_inst, want);
            end
         end
         if (t < 20) begin
            n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_in_ready[%0d] got %b want 1", t, in_ready); end
            drive_req(3'd1, 7'h13, 3'd0, 7'h00, t[4:0], 5'd0, 5'd0, t);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      n_vec++; if (out_valid !== 1'b0 || enc_count !== 16'd20) begin
         n_miss++; $display("FAIL b2b_enc_count got v%b %0d want v0 20", out_valid, enc_count);
      end
      n_vec++; if (enc_count4 !== 4'd4) begin
         n_miss++; $display("FAIL b2b_enc_count_wrap got %0d want 4", enc_count4);
      end
   endtask

   task automatic test_err_saturate();
      pulse_reset();
      for (int t = 0; t < 17; t++) begin
         drive_req(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++; if (err_count !== 16'd17 || enc_count !== 16'd17) begin
         n_miss++; $display("FAIL sat_wide got err %0d enc %0d want 17 17", err_count, enc_count);
      end
      n_vec++; if (err_count4 !== 4'hF) begin
         n_miss++; $display("FAIL sat_err_count4 got %0d want 15", err_count4);
      end
      n_vec++; if (enc_count4 !== 4'd1) begin
         n_miss++; $display("FAIL sat_enc_count4 got %0d want 1", enc_count4);
      end
   endtask

   task automatic test_async_reset();
      for (int t = 0; t < 4; t++) begin
         drive_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'd9);
         @(negedge clk);
      end
      n_vec++; if (out_valid !== 1'b1 || out_inst !== 32'h0090_0493) begin
         n_miss++; $display("FAIL arst_pre got v%b %h want v1 00900493", out_valid, out_inst);
      end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0) begin
         n_miss++; $display("FAIL arst_outputs got v%b %h e%b want v0 00000000 e0", out_valid, out_inst, out_err);
      end
      n_vec++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin
         n_miss++; $display("FAIL arst_counters got %0d/%0d want 0/0", enc_count, err_count);
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL arst_no_stale got %b want 0", out_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_encode();
      test_errors();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_err_saturate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
